// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, is_signed    - request (sampled in IDLE), 1 = signed DIV
//   dividend, divisor   - operands, sampled with start
//   cancel              - abort the operation in flight
//   busy, done          - in-flight flag, one-cycle completion pulse
//   quotient, remainder - LO/HI results, held until the next completion
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] prem, prem_d;     // partial remainder
  logic [WIDTH-1:0] work, work_d;     // working dividend, fills with quotient bits
  logic [WIDTH-1:0] dsr, dsr_d;       // divisor magnitude
  logic [WIDTH-1:0] raw, raw_d;       // dividend as presented, for divide-by-zero
  logic             qneg, qneg_d;
  logic             rneg, rneg_d;
  logic             dz, dz_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next, quo_next;

  // Next-state, datapath and output logic.
  always_comb begin
    state_d     = state;
    prem_d      = prem;
    work_d      = work;
    dsr_d       = dsr;
    raw_d       = raw;
    qneg_d      = qneg;
    rneg_d      = rneg;
    dz_d        = dz;
    cnt_d       = cnt;
    quotient_d  = quotient;
    remainder_d = remainder;

    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    mag_a = a_neg ? WIDTH'(0) - dividend : dividend;
    mag_b = b_neg ? WIDTH'(0) - divisor  : divisor;

    // One restoring step; a set top bit after the shift always exceeds the divisor.
    rem_sh   = {prem, work[WIDTH-1]};
    diff     = rem_sh - {1'b0, dsr};
    fits     = rem_sh[WIDTH] | ~diff[WIDTH];
    rem_next = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {work[WIDTH-2:0], fits};

    unique case (state)
      IDLE: begin
        if (start) begin
          prem_d  = '0;
          work_d  = mag_a;
          dsr_d   = mag_b;
          raw_d   = dividend;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (divisor == '0);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          prem_d = rem_next;
          work_d = quo_next;
          cnt_d  = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            quotient_d  = dz ? '1 : (qneg ? WIDTH'(0) - quo_next : quo_next);
            remainder_d = dz ? raw : (rneg ? WIDTH'(0) - rem_next : rem_next);
            state_d     = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prem      <= '0;
      work      <= '0;
      dsr       <= '0;
      raw       <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state     <= state_d;
      prem      <= prem_d;
      work      <= work_d;
      dsr       <= dsr_d;
      raw       <= raw_d;
      qneg      <= qneg_d;
      rneg      <= rneg_d;
      dz        <= dz_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table plus
// restart, cancel and mid-operation reset sequences.
module tb_div_unit;

  localparam int NONE = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] quotient, remainder;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[11];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Caller is at the negedge of cycle 0. Observes cycles 1..ncyc and returns
  // at the negedge of cycle ncyc with idle inputs driven for that cycle.
  task automatic run_op(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input int restart_cyc, input int cancel_cyc, input int rst_cyc,
                        input int ncyc);
    int abort;
    bit bad;
    int bc;
    logic eb, ed, hold, bb, bd, beb, bed;
    logic [31:0] hq, hr, bq, br, bhq, bhr;
    abort = (cancel_cyc < rst_cyc) ? cancel_cyc : rst_cyc;
    bad = 0;
    bc = 0; bb = 0; bd = 0; beb = 0; bed = 0;
    bq = '0; br = '0; bhq = '0; bhr = '0;
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b; cancel = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      eb   = (cyc <= 33) && (cyc <= abort);
      ed   = (cyc == 33) && (abort >= 33);
      hold = (cyc <= 32) || (abort <= 32);
      hq   = (cyc > rst_cyc) ? 32'h0 : prev_q;
      hr   = (cyc > rst_cyc) ? 32'h0 : prev_r;
      if (!bad && (busy !== eb || done !== ed ||
                   (hold && (quotient !== hq || remainder !== hr)))) begin
        bad = 1; bc = cyc; bb = busy; bd = done; bq = quotient; br = remainder;
        beb = eb; bed = ed; bhq = hold ? hq : quotient; bhr = hold ? hr : remainder;
      end
      start  = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        dividend = 32'd9; divisor = 32'd3;
      end
      cancel = (cyc == cancel_cyc);
      rst    = (cyc == rst_cyc);
    end
    n_vec++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s timing: cycle %0d busy=%b done=%b q=%h r=%h, expected busy=%b done=%b q=%h r=%h",
               nm, bc, bb, bd, bq, br, beb, bed, bhq, bhr);
    end
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3]  = '{1'b0, 32'h12345678, 32'd0,         32'hFFFFFFFF, 32'h12345678};
    vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[5]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9, 32'd0,         32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[7]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,         32'h80000000};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,         32'd0};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'd1,         32'hFFFFFFFF, 32'd0};
    vecs[10] = '{1'b0, 32'd5,         32'd10,        32'd0,         32'd5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, NONE, NONE, NONE, 34);

    run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, NONE, NONE, NONE, 34);
    run_op("start ignored 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 10, NONE, NONE, 34);
    run_op("cancel c15", 1'b0, 32'd1000, 32'd3, 32'd10, 32'd0, NONE, 15, NONE, 16);
    run_op("start after cancel 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, NONE, NONE, NONE, 34);
    run_op("cancel on last iter", 1'b0, 32'd77, 32'd7, 32'd3, 32'd0, NONE, 32, NONE, 34);
    run_op("cancel in done", 1'b0, 32'd77, 32'd7, 32'd11, 32'd0, NONE, 33, NONE, 34);
    run_op("reset c20", 1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, NONE, NONE, 20, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the DIV/DIVU instructions, instantiated inside `top_cpu` next to the execute-stage ALU. It accepts a start pulse with two operands and runs a radix-2 restoring division over 32 iterations. It then presents quotient (LO) and remainder (HI) with a one-cycle `done` pulse. The control unit holds the PC and suppresses register writeback while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is required; the iteration counter is sized as clog2(WIDTH)+1.
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: request a division. Sampled only in IDLE.
- `is_signed`, in, 1: 1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `dividend`, in, WIDTH: numerator. Sampled with `start`.
- `divisor`, in, WIDTH: denominator. Sampled with `start`.
- `cancel`, in, 1: abort the operation in flight (exception/flush).
- `busy`, out, 1: high while an operation is in flight (states CALC and DONE).
- `done`, out, 1: one-cycle pulse when results are valid.
- `quotient`, out, WIDTH: LO result. Registered and held until the next completion.
- `remainder`, out, WIDTH: HI result. Registered and held until the next completion.

## Operation
- States are IDLE, CALC and DONE. Reset and `cancel` both force IDLE.
- **IDLE, with `start`=1:**
  - Latch the magnitudes |dividend| and |divisor|. Magnitudes apply only when `is_signed`=1; otherwise the raw values are used.
  - Latch the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Latch a divide-by-zero flag.
  - Clear the partial remainder and set the counter to 0. Next state is CALC.
- **CALC, each cycle:**
  - Shift {partial remainder, working dividend} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Increment the counter.
  - On the 32nd iteration, register the final results into `quotient`/`remainder` and go to DONE.
- **Sign correction:** applied when the final results are registered.
  - Negate the quotient if the quotient sign is 1.
  - Negate the remainder if the remainder sign is 1.
  - All arithmetic is modulo 2^WIDTH. The subtractor is WIDTH+1 bits wide to detect borrow.
- **Divide by zero** (divisor = 0, either signedness):
  - Runs the full latency.
  - Forces `quotient`=0xFFFFFFFF and `remainder`=dividend as originally presented (not the magnitude).
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): `quotient`=0x80000000, `remainder`=0.
- **DONE:** `done`=1 for exactly one cycle. Next state is IDLE.
- **Ignored inputs:**
  - `start` in CALC or DONE is ignored. No queuing; operands are not re-sampled.
  - `start` and `cancel` together in IDLE: the start is accepted, because `cancel` has no effect in IDLE.
- **`cancel`:**
  - `cancel` in CALC or DONE returns to IDLE at the next edge.
  - No `done` is produced, and `quotient`/`remainder` keep their previous values.
  - If `cancel` coincides with the 32nd iteration, `cancel` wins: results are not updated.
  - If `cancel` arrives in the DONE cycle, the `done` pulse in that cycle is already visible, and the results are already updated.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, counter 0.
- **Reset mid-operation:** all outputs return to their reset values at the next edge.
- **Latency:** `start` is high in cycle 0 (sampled at the end of cycle 0).
  - `busy` is high in cycles 1..33.
  - The result registers update at the end of cycle 32.
  - `done` is high in cycle 33.
  - `busy` is low again in cycle 34.
  - The earliest next accepted `start` is in cycle 34.
- **Output registers:** all outputs are registered. There is no combinational path from inputs to outputs.
- **Result hold:** `quotient`/`remainder` change only at the end of cycle 32 of a non-cancelled operation, or on reset.

## Test plan
- **Unsigned:** DIVU 100 / 7 -> `done` in cycle 33 exactly, `quotient`=14, `remainder`=2; `busy` high cycles 1..33.
- **Signed:** DIV 0xFFFFFFF9 (-7) / 2 -> `quotient`=0xFFFFFFFD (-3), `remainder`=0xFFFFFFFF (-1).
- **Signed, negative divisor:** DIV 7 / 0xFFFFFFFE (-2) -> `quotient`=0xFFFFFFFD, `remainder`=1.
- **Corner cases:**
  - DIVU 0x12345678 / 0 -> `quotient`=0xFFFFFFFF, `remainder`=0x12345678, same latency.
  - DIV 0x80000000 / 0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0.
- **Busy and cancel:** after a completed 100/7, start 50/5 and pulse `start` again in cycle 10 with 9/3 -> ignored, results 10/0. Then start 1000/3 and assert `cancel` in cycle 15 -> IDLE in cycle 16, no `done`, outputs still 10/0; a new start in cycle 16 is accepted.
- **Reset mid-operation:** assert `rst` in cycle 20 of an operation -> next cycle `busy`=0, `done`=0, `quotient`=`remainder`=0; no `done` pulse ever appears for the aborted operation.
